// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped FIFO: data port pushes/pops, status and control registers,
// one-cycle read responses tagged with the request's transaction ID.
module mmio_fifo_ctrl #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] FIFO_ADDR = 16'h0020,
  parameter logic [15:0] STAT_ADDR = 16'h0022,
  parameter logic [15:0] CTRL_ADDR = 16'h0024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_addr,
  input  logic [8:0]  rd_tid,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic [8:0]  fifo_count,
  output logic        fifo_empty,
  output logic        fifo_full
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DMAX = 9'(DEPTH);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          udf;
  logic          ovf;

  logic          push_req;
  logic          pop_req;
  logic          stat_req;
  logic          ctrl_rd;
  logic          ctrl_wr;
  logic          push_ok;
  logic          pop_ok;
  logic          flush;
  logic          clr;
  logic          any_rd;
  logic [8:0]    cnt_n;
  logic [63:0]   stat_word;
  logic [63:0]   rd_word;

  assign push_req = wr_valid && (wr_addr == FIFO_ADDR);
  assign ctrl_wr  = wr_valid && (wr_addr == CTRL_ADDR);
  assign pop_req  = rd_valid && (rd_addr == FIFO_ADDR);
  assign stat_req = rd_valid && (rd_addr == STAT_ADDR);
  assign ctrl_rd  = rd_valid && (rd_addr == CTRL_ADDR);
  assign any_rd   = pop_req || stat_req || ctrl_rd;

  // Registered flags are the pre-edge state both requests are judged by.
  assign push_ok  = push_req && !fifo_full;
  assign pop_ok   = pop_req && !fifo_empty;
  assign flush    = ctrl_wr && wr_data[0];
  assign clr      = ctrl_wr && wr_data[1];

  assign stat_word = {44'd0, ovf, udf, fifo_full, fifo_empty,
                      7'd0, fifo_count};

  always_comb begin
    cnt_n = fifo_count;
    if (flush)
      cnt_n = '0;
    else if (push_ok && !pop_ok)
      cnt_n = fifo_count + 9'd1;
    else if (pop_ok && !push_ok)
      cnt_n = fifo_count - 9'd1;
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      pop_req:  rd_word = pop_ok ? mem[rp] : '0;
      stat_req: rd_word = stat_word;
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      udf        <= 1'b0;
      ovf        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_tid    <= '0;
      rsp_data   <= '0;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push_ok) wp <= wp + PONE;
        if (pop_ok)  rp <= rp + PONE;
      end
      fifo_count <= cnt_n;
      fifo_empty <= (cnt_n == 9'd0);
      fifo_full  <= (cnt_n == DMAX);
      // A same-cycle event beats a clear.
      udf        <= (pop_req && !pop_ok) || (udf && !clr);
      ovf        <= (push_req && !push_ok) || (ovf && !clr);
      rsp_valid  <= any_rd;
      if (any_rd) begin
        rsp_tid  <= rd_tid;
        rsp_data <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wp] <= wr_data;
  end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Bench for mmio_fifo_ctrl: directed vector table, corner sequences
// and random traffic checked against a queue-based model.
module tb_mmio_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam logic [15:0] FA  = 16'h0020;
  localparam logic [15:0] SA  = 16'h0022;
  localparam logic [15:0] CA  = 16'h0024;
  localparam logic [15:0] BAD = 16'h0030;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [8:0]  rd_tid;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [8:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;

  mmio_fifo_ctrl #(
    .DEPTH(DEPTH), .FIFO_ADDR(FA),
    .STAT_ADDR(SA), .CTRL_ADDR(CA)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_tid(rd_tid),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid),
    .rsp_data(rsp_data),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  bit          m_udf;
  bit          m_ovf;
  logic        m_rv;
  logic [8:0]  m_tid;
  logic [63:0] m_data;

  typedef struct {
    logic        wv;
    logic [15:0] wa;
    logic [63:0] wd;
    logic        rv;
    logic [15:0] ra;
    logic [8:0]  tid;
    logic        exp_rv;
    logic [63:0] exp_data;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_stat();
    int n;
    n = q.size();
    return 64'(n)
         + (64'(n == 0) << 16)
         + (64'(n == DEPTH) << 17)
         + (64'(m_udf) << 18)
         + (64'(m_ovf) << 19);
  endfunction

  task automatic model_reset();
    q.delete();
    m_udf  = 0;
    m_ovf  = 0;
    m_rv   = 0;
    m_tid  = '0;
    m_data = '0;
  endtask

  // Judges this cycle's inputs against the pre-edge queue contents.
  task automatic model_step();
    int n;
    bit ue;
    bit oe;
    n  = q.size();
    ue = 0;
    oe = 0;
    m_rv = 0;
    if (rd_valid && (rd_addr == FA || rd_addr == SA
                     || rd_addr == CA)) begin
      m_rv  = 1;
      m_tid = rd_tid;
      if (rd_addr == FA)
        m_data = (n > 0) ? q[0] : 64'd0;
      else if (rd_addr == SA)
        m_data = m_stat();
      else
        m_data = 64'd0;
    end
    if (rd_valid && rd_addr == FA) begin
      if (n > 0) void'(q.pop_front());
      else ue = 1;
    end
    if (wr_valid && wr_addr == FA) begin
      if (n < DEPTH) q.push_back(wr_data);
      else oe = 1;
    end
    if (wr_valid && wr_addr == CA) begin
      if (wr_data[0]) q.delete();
      if (wr_data[1]) begin
        m_udf = 0;
        m_ovf = 0;
      end
    end
    if (ue) m_udf = 1;
    if (oe) m_ovf = 1;
  endtask

  task automatic cmp();
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_tid", rsp_tid, m_tid);
    chk("rsp_data", rsp_data, m_data);
    chk("fifo_count", fifo_count, q.size());
    chk("fifo_empty", fifo_empty, q.size() == 0);
    chk("fifo_full", fifo_full, q.size() == DEPTH);
  endtask

  task automatic cyc(input logic wv, input logic [15:0] wa,
                     input logic [63:0] wd, input logic rv,
                     input logic [15:0] ra, input logic [8:0] tid);
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    rd_tid   = tid;
    model_step();
    @(posedge clk);
    #1;
    cmp();
    wr_valid = 0;
    rd_valid = 0;
  endtask

  task automatic push(input logic [63:0] d);
    cyc(1, FA, d, 0, 16'd0, 9'd0);
  endtask

  task automatic pop(input logic [8:0] tid);
    cyc(0, 16'd0, 64'd0, 1, FA, tid);
  endtask

  task automatic rstat(input logic [8:0] tid);
    cyc(0, 16'd0, 64'd0, 1, SA, tid);
  endtask

  task automatic wctrl(input logic [63:0] d);
    cyc(1, CA, d, 0, 16'd0, 9'd0);
  endtask

  task automatic do_reset();
    wr_valid = 0;
    rd_valid = 0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    rd_tid   = '0;
    rst      = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tid", rsp_tid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    rst = 0;
  endtask

  function automatic vec_t mk(
      input logic wv, input logic [15:0] wa,
      input logic [63:0] wd, input logic rv,
      input logic [15:0] ra, input logic [8:0] tid,
      input logic erv, input logic [63:0] ed,
      input logic [8:0] ec);
    vec_t v;
    v.wv = wv;  v.wa = wa;   v.wd = wd;
    v.rv = rv;  v.ra = ra;   v.tid = tid;
    v.exp_rv = erv;
    v.exp_data = ed;
    v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, FA, 64'h11 + 64'(i), 0, 0, 0,
                       0, 0, 9'(i + 1)));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 1, FA, 9'(8 + i),
                       1, 64'h11 + 64'(i), 9'(7 - i)));
    tbl.push_back(mk(0, 0, 0, 1, SA, 9'd16,
                     1, 64'h0001_0000, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, FA, 64'h21 + 64'(i), 0, 0, 0,
                       0, 0, (i < 8) ? 9'(i + 1) : 9'd8));
    tbl.push_back(mk(0, 0, 0, 1, SA, 9'd26,
                     1, 64'h000A_0008, 8));
    tbl.push_back(mk(1, CA, 2, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 1, SA, 9'd28,
                     1, 64'h0002_0008, 8));
    tbl.push_back(mk(1, CA, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FA, 9'd30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, SA, 9'd31,
                     1, 64'h0005_0000, 0));
    tbl.push_back(mk(0, 0, 0, 1, BAD, 9'd32, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, CA, 9'd33, 1, 0, 0));

    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].wv, tbl[i].wa, tbl[i].wd,
          tbl[i].rv, tbl[i].ra, tbl[i].tid);
      chk($sformatf("vec%0d_rv", i), rsp_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) begin
        chk($sformatf("vec%0d_data", i), rsp_data,
            tbl[i].exp_data);
        chk($sformatf("vec%0d_tid", i), rsp_tid, tbl[i].tid);
      end
      chk($sformatf("vec%0d_cnt", i), fifo_count,
          tbl[i].exp_cnt);
    end

    // Full FIFO with simultaneous push and pop.
    wctrl(3);
    for (int i = 0; i < 8; i++) push(64'hB0 + 64'(i));
    cyc(1, FA, 64'hAA, 1, FA, 9'd5);
    chk("full_pp_data", rsp_data, 64'hB0);
    chk("full_pp_cnt", fifo_count, 7);
    rstat(9'd6);
    chk("full_pp_stat", rsp_data, 64'h0008_0007);
    wctrl(3);
    for (int i = 0; i < 3; i++) push(64'hD0 + 64'(i));
    cyc(1, FA, 64'hD3, 1, FA, 9'd7);
    chk("mid_pp_data", rsp_data, 64'hD0);
    chk("mid_pp_cnt", fifo_count, 3);

    // Pointer wrap over several fill/drain rounds, then flush.
    wctrl(3);
    for (int i = 0; i < 3; i++) push(64'hE0 + 64'(i));
    for (int r = 0; r < 3; r++) begin
      while (q.size() < DEPTH) push(64'($urandom));
      for (int i = 0; i < DEPTH; i++) pop(9'(r * 8 + i));
    end
    push(64'h1234);
    push(64'h5678);
    wctrl(1);
    chk("flush_cnt", fifo_count, 0);
    pop(9'd100);
    chk("flush_pop_data", rsp_data, 0);
    rstat(9'd101);
    chk("flush_stat", rsp_data, 64'h0005_0000);
    cyc(0, 0, 0, 1, BAD, 9'd102);
    chk("bad_addr_rv", rsp_valid, 0);

    // Flush and pop together; clear and underflow together.
    wctrl(3);
    push(64'hC1);
    push(64'hC2);
    cyc(1, CA, 64'd1, 1, FA, 9'd7);
    chk("flush_pop_data", rsp_data, 64'hC1);
    chk("flush_pop_cnt", fifo_count, 0);
    cyc(1, CA, 64'd2, 1, FA, 9'd8);
    rstat(9'd9);
    chk("clr_udf_stat", rsp_data, 64'h0005_0000);

    // Reset right after a pop request is accepted.
    push(64'hF1);
    rd_valid = 1;
    rd_addr  = FA;
    rd_tid   = 9'd77;
    @(posedge clk);
    rst = 1;
    rd_valid = 0;
    model_reset();
    #1;
    chk("mid_rst_rv", rsp_valid, 0);
    chk("mid_rst_tid", rsp_tid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);

    // Random traffic, biased in phases to reach full and empty.
    for (int i = 0; i < 600; i++) begin
      logic        wv;
      logic        rv;
      logic [15:0] wa;
      logic [15:0] ra;
      logic [63:0] wd;
      int          pw;
      int          sel;
      pw  = ((i / 50) % 2 == 0) ? 75 : 25;
      wv  = ($urandom_range(0, 99) < pw);
      rv  = ($urandom_range(0, 99) < 100 - pw);
      sel = $urandom_range(0, 19);
      wa  = (sel == 0) ? CA : (sel == 1) ? BAD : FA;
      sel = $urandom_range(0, 19);
      ra  = (sel < 3) ? SA : (sel == 3) ? CA
          : (sel == 4) ? BAD : FA;
      wd  = {$urandom, $urandom};
      if (wa == CA)
        wd = 64'($urandom_range(0, 3));
      cyc(wv, wa, wd, rv, ra, 9'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_ctrl.md
MMIO_FIFO_CTRL -- requirements
Module: mmio_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter FIFO_ADDR, default 16'h0020, MMIO data-port address.
REQ-003 SHALL have parameter STAT_ADDR, default 16'h0022, MMIO status address.
REQ-004 SHALL have parameter CTRL_ADDR, default 16'h0024, MMIO control address.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_valid  input  1  MMIO write strobe, one cycle per write.
REQ-008 SHALL have port wr_addr  input  16  MMIO write address.
REQ-009 SHALL have port wr_data  input  64  MMIO write data.
REQ-010 SHALL have port rd_valid  input  1  MMIO read strobe, one cycle per read.
REQ-011 SHALL have port rd_addr  input  16  MMIO read address.
REQ-012 SHALL have port rd_tid  input  9  MMIO read transaction ID.
REQ-013 SHALL have port rsp_valid  output  1  read-response strobe.
REQ-014 SHALL have port rsp_tid  output  9  echoed transaction ID.
REQ-015 SHALL have port rsp_data  output  64  read-response data.
REQ-016 SHALL have port fifo_count  output  9  current occupancy, 0..DEPTH.
REQ-017 SHALL have port fifo_empty  output  1  fifo_count==0.
REQ-018 SHALL have port fifo_full  output  1  fifo_count==DEPTH.

Function
REQ-019 Push: wr_valid & wr_addr==FIFO_ADDR & !full -> store wr_data at write pointer, pointer+1 mod DEPTH, count+1.
REQ-020 Push when full -> data dropped, pointers/count unchanged, sticky ovf set.
REQ-021 Pop: rd_valid & rd_addr==FIFO_ADDR & !empty -> rsp_data = entry at read pointer, pointer+1 mod DEPTH, count-1.
REQ-022 Pop when empty -> rsp_data = 0, state unchanged, sticky udf set.
REQ-023 Simultaneous push and pop SHALL both be judged against pre-edge count: count 0 -> pop underflows (zero data, udf set), push accepted, count becomes 1; count DEPTH -> pop succeeds, push dropped (ovf set), count becomes DEPTH-1; otherwise both succeed, count unchanged.
REQ-024 Status read (rd_addr==STAT_ADDR): rsp_data[8:0]=count, [16]=empty, [17]=full, [18]=udf, [19]=ovf, all other bits 0; values are pre-edge state.
REQ-025 Control read (rd_addr==CTRL_ADDR) SHALL return 64'h0.
REQ-026 Control write: wr_data[0]=1 flush (pointers and count to 0); wr_data[1]=1 clear udf and ovf; other bits ignored.
REQ-027 Flush with same-cycle pop: response uses pre-flush state; post-edge state is empty. Clear with same-cycle overflow/underflow event: the flag from that event SHALL remain set (set wins).
REQ-028 rsp_valid SHALL pulse exactly one cycle, one clock after any rd_valid whose rd_addr is FIFO_ADDR, STAT_ADDR or CTRL_ADDR; rsp_tid = that cycle's rd_tid.
REQ-029 rd_valid at any other address SHALL produce no response and no state change; wr_valid at other addresses SHALL be ignored.
REQ-030 Back-to-back reads/writes every cycle SHALL be supported with no stall; each read gets its own response in order.
REQ-031 rsp_data and rsp_tid SHALL hold last value when rsp_valid=0.
REQ-032 fifo_count/fifo_empty/fifo_full SHALL be registered, reflecting post-edge state.

Reset
REQ-033 On rst: rsp_valid=0, rsp_tid=0, rsp_data=0, pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, udf=ovf=0.
REQ-034 FIFO storage SHALL NOT require reset; contents are unobservable until written.
REQ-035 Reset asserted mid-operation SHALL cancel any pending response (no rsp_valid after rst deasserts until a new read).

Verification
REQ-036 Push 8'h11..8'h18 (8 writes to 0x20), pop 8 times -> rsp_data 0x11..0x18 in order, tids echoed, final status 0x0001_0000.
REQ-037 Push 9 values with DEPTH=8 -> 9th dropped, status reads 0x000A_0008 (count 8, full, ovf); write CTRL=2 -> status 0x0002_0008.
REQ-038 Pop on empty -> rsp_data 0, status 0x0005_0000 (empty, udf).
REQ-039 Full FIFO, same-cycle push 0xAA and pop -> pop returns oldest entry, 0xAA dropped, count 7, ovf set; at count 3 same-cycle push/pop -> count stays 3.
REQ-040 Push 3 values, wrap pointers over 3 full fill/drain cycles, then CTRL write 1 -> count 0, next pop returns 0 with udf; read 0x30 -> no rsp_valid.
REQ-041 Assert rst the cycle after a pop request -> no rsp_valid; all outputs at reset values.
